// File: rtl/vc_tx_scheduler.sv
// vc_tx_scheduler: credit-aware, packet-atomic round-robin scheduler for one
// NoC output link. Picks one valid and credited VC per cycle. After a packet
// head is accepted, the link is held on that VC until its last flit goes out.
module vc_tx_scheduler #(
    parameter int VC_W = 4,
    parameter int D_W  = 8,
    parameter int A_W  = 4,
    localparam int FW  = A_W + D_W + 1,
    localparam int LW  = (VC_W > 1) ? $clog2(VC_W) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [VC_W-1:0]      s_v,
    input  logic [VC_W*FW-1:0]   s_d,
    output logic [VC_W-1:0]      s_b,
    output logic [VC_W-1:0]      m_v,
    output logic [FW-1:0]        m_d,
    input  logic [VC_W-1:0]      m_b,
    output logic                 o_locked,
    output logic [LW-1:0]        o_lock_vc
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state_reg;
    logic [LW-1:0]   rr_ptr_reg;
    logic [LW-1:0]   lock_vc_reg;

    logic [FW-1:0]   word [VC_W];
    logic [VC_W-1:0] elig;
    logic            found;
    logic [LW-1:0]   grant;
    int              idx;
    logic            xfer;
    logic            last;

    // Per-VC flit words and eligibility (valid and credited).
    generate
        for (genvar gi = 0; gi < VC_W; gi++) begin : g_unpack
            assign word[gi] = s_d[gi*FW +: FW];
            assign elig[gi] = s_v[gi] & ~m_b[gi];
        end
    endgenerate

    // Round-robin search starting at rr_ptr, wrapping modulo VC_W.
    always_comb begin
        idx   = 0;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < VC_W; i++) begin
            idx = int'(rr_ptr_reg) + i;
            if (idx >= VC_W) begin
                idx = idx - VC_W;
            end
            if (!found && elig[idx]) begin
                found = 1'b1;
                grant = LW'(idx);
            end
        end
    end

    // Output mux: free grant in IDLE, locked VC only while LOCKED; reset forces
    // a quiet link with every source stalled.
    always_comb begin
        m_v = '0;
        s_b = '1;
        m_d = word[rr_ptr_reg];
        if (state_reg == LOCKED) begin
            m_d = word[lock_vc_reg];
            if (!rst) begin
                s_b[lock_vc_reg] = m_b[lock_vc_reg];
                m_v[lock_vc_reg] = elig[lock_vc_reg];
            end
        end else if (found) begin
            m_d = word[grant];
            if (!rst) begin
                m_v = VC_W'(1) << grant;
                s_b = ~m_v;
            end
        end
    end

    // m_v already excludes backpressured VCs, so any set bit is a transfer.
    assign xfer = |m_v;
    assign last = m_d[FW-1];

    // Next-pointer helper: wraps at VC_W so non-power-of-two counts work.
    function automatic logic [LW-1:0] rr_inc(input logic [LW-1:0] v);
        if (int'(v) >= VC_W - 1) begin
            return '0;
        end
        return v + LW'(1);
    endfunction

    // Packet-lock FSM and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            rr_ptr_reg  <= '0;
            lock_vc_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (xfer) begin
                        if (last) begin
                            rr_ptr_reg <= rr_inc(grant);
                        end else begin
                            state_reg   <= LOCKED;
                            lock_vc_reg <= grant;
                        end
                    end
                end
                LOCKED: begin
                    if (xfer && last) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= rr_inc(lock_vc_reg);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign o_locked  = (state_reg == LOCKED) & ~rst;
    assign o_lock_vc = lock_vc_reg;

`ifndef SYNTHESIS
    // Link-protocol invariants.
    a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(m_v));
    a_credit : assert property (@(posedge clk) disable iff (rst) (m_v & m_b) == '0);
    a_lock   : assert property (@(posedge clk) disable iff (rst)
                   (state_reg == LOCKED) |-> ((m_v & ~(VC_W'(1) << lock_vc_reg)) == '0));
    a_known  : assert property (@(posedge clk) disable iff (rst)
                   !$isunknown(m_v) && !$isunknown(s_b));
`endif

endmodule
